// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, key code constants and helpers for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD} state_t;
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;
  function automatic logic [1:0] idx4(input logic [3:0] oh);
    return oh[0] ? 2'd0 : oh[1] ? 2'd1 : oh[2] ? 2'd2 : 2'd3;
  endfunction
  function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
    return col_idx == 2'd3 ? (row_idx == 2'd0 ? KEY_A : row_idx == 2'd1 ? KEY_B : row_idx == 2'd2 ? KEY_C : KEY_D) :
           row_idx == 2'd3 ? (col_idx == 2'd0 ? KEY_STAR : col_idx == 2'd1 ? 4'd0 : KEY_HASH) :
           4'(row_idx * 3 + col_idx + 1);
  endfunction
endpackage

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen: one-clk scan tick every CLK_HZ/SCAN_HZ clocks
module keypad_tick_gen #(
  parameter int CLK_HZ  = 27_000_000,
  parameter int SCAN_HZ = 1_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad scan, press/release debounce and one-entry key event buffer.
// Define KEYPAD_AUTOREPEAT_EN to add auto-repeat events while a key stays held.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int CLK_HZ       = 27_000_000,
  parameter int SCAN_HZ      = 1_000,
  parameter int DEBOUNCE_TKS = 8,
  parameter int REPEAT_DLY   = 500,
  parameter int REPEAT_PER   = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);
  if (CLK_HZ / SCAN_HZ < 2) $error("scan tick divider must be at least 2");
  if (DEBOUNCE_TKS < 1 || DEBOUNCE_TKS > 255) $error("DEBOUNCE_TKS out of range");
  if (REPEAT_DLY < 1 || REPEAT_PER < 1) $error("repeat intervals must be positive");
  state_t state, state_nx;
  logic tick, one_low, idle, match, db_done, ev_press, ev_rpt, ev, xfer;
  logic [3:0] row_m, row_s, low, lat_rows, lat_code;
  logic [7:0] db_cnt;
  keypad_tick_gen #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));
  assign low     = ~row_s;
  assign one_low = low != 4'd0 && (low & (low - 4'd1)) == 4'd0;
  assign idle    = row_s == 4'hF;
  assign match   = row_s == lat_rows;
  assign db_done = db_cnt == 8'(DEBOUNCE_TKS - 1);
  assign xfer    = key_valid & key_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= SCAN;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (tick)
      case (state)
        SCAN:     state_nx = one_low ? PRESS_DB : SCAN;
        PRESS_DB: state_nx = !match ? SCAN : db_done ? HELD : PRESS_DB;
        HELD:     state_nx = idle && db_done ? SCAN : HELD;
        default:  state_nx = SCAN;
      endcase
  end
  always_comb begin
    ev_press = tick && state == PRESS_DB && match && db_done;
    ev       = ev_press | ev_rpt;
  end
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [15:0] rpt_cnt;
  logic rpt_first;
  assign ev_rpt = tick && state == HELD && match &&
                  rpt_cnt == 16'(rpt_first ? REPEAT_DLY - 1 : REPEAT_PER - 1);
  // counts only ticks where the key is still down, so release debounce never repeats
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (state != HELD) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (tick && match) begin
      rpt_cnt   <= ev_rpt ? '0 : rpt_cnt + 16'd1;
      rpt_first <= rpt_first & ~ev_rpt;
    end
`else
  assign ev_rpt = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row_m    <= 4'hF;
      row_s    <= 4'hF;
      col_o    <= 4'b1110;
      lat_rows <= 4'hF;
      lat_code <= 4'd0;
      db_cnt   <= 8'd0;
      key_held <= 1'b0;
    end else begin
      row_m    <= row_i;
      row_s    <= row_m;
      key_held <= state_nx == HELD;
      if (tick && state == SCAN && !one_low) col_o <= {col_o[2:0], col_o[3]};
      if (tick && state == SCAN && one_low) begin
        lat_rows <= row_s;
        lat_code <= keymap(idx4(low), idx4(~col_o));
      end
      if (state_nx != state) db_cnt <= 8'd0;
      else if (tick && state == PRESS_DB) db_cnt <= db_cnt + 8'd1;
      else if (tick && state == HELD) db_cnt <= idle ? db_cnt + 8'd1 : 8'd0;
    end
  // one-entry buffer: a new event replaces only an empty or simultaneously drained slot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= ev && key_valid && !key_ready;
      if (ev && (!key_valid || key_ready)) begin
        key_code  <= lat_code;
        key_valid <= 1'b1;
      end else if (xfer) key_valid <= 1'b0;
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed checks of scan, debounce, key map, handshake and reset
module tb_keypad_scan_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, key_ready = 1'b0;
  logic [3:0] row_i, col_o, key_code, c;
  logic key_valid, key_held, overrun;
  logic [15:0] keys_down = '0;
  logic [3:0] force_low = '0;
  logic [3:0] last_code = '0;
  int n_chk = 0, n_err = 0, n_ev = 0, n_ovr = 0, base;
  bit ok;
  keypad_scan_ctrl #(.CLK_HZ(8), .SCAN_HZ(1), .DEBOUNCE_TKS(3), .REPEAT_DLY(5), .REPEAT_PER(2)) dut (
    .clk(clk), .rst_n(rst_n), .row_i(row_i), .col_o(col_o), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always_comb begin
    row_i = ~force_low;
    for (int r = 0; r < 4; r++)
      if (|(keys_down[r*4 +: 4] & ~col_o)) row_i[r] = 1'b0;
  end
  always @(negedge clk)
    if (rst_n) begin
      if (key_valid && key_ready) begin
        n_ev++;
        last_code = key_code;
      end
      if (overrun) n_ovr++;
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    clks(8 * n);
  endtask
  initial begin
    clks(3);
    check("rst_col", col_o, 4'b1110);
    check("rst_code", key_code, 0);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    key_ready = 1'b1;
    keys_down[5] = 1'b1;
    ticks(20);
    check("t1_held", key_held, 1);
    check("t1_events", n_ev, 1);
    check("t1_code", last_code, 5);
    keys_down[5] = 1'b0;
    ticks(1);
    check("t1_held_early", key_held, 1);
    ticks(4);
    check("t1_released", key_held, 0);
    check("t1_single", n_ev, 1);
    key_ready = 1'b0;
    keys_down[13] = 1'b1;
    ticks(10);
    check("t2_valid0", key_valid, 1);
    check("t2_code0", key_code, 0);
    keys_down[13] = 1'b0;
    key_ready = 1'b1;
    clks(2);
    check("t2_drained", key_valid, 0);
    check("t2_xfer0", last_code, 0);
    ticks(6);
    keys_down[15] = 1'b1;
    ticks(10);
    check("t2_code_d", last_code, 13);
    keys_down[15] = 1'b0;
    ticks(6);
    check("t2_events", n_ev, 3);
    force_low = 4'b0010;
    ticks(2);
    force_low = 4'b0000;
    ticks(3);
    check("t3_no_event", n_ev, 3);
    check("t3_not_held", key_held, 0);
    c = col_o;
    clks(8);
    check("t3_rotate", col_o, {c[2:0], c[3]});
    key_ready = 1'b0;
    keys_down[0] = 1'b1;
    ticks(8);
    keys_down[0] = 1'b0;
    ticks(6);
    keys_down[1] = 1'b1;
    ticks(8);
    keys_down[1] = 1'b0;
    ticks(6);
    check("t4_valid", key_valid, 1);
    check("t4_kept", key_code, 1);
    check("t4_overrun", n_ovr, 1);
    key_ready = 1'b1;
    clks(2);
    check("t4_drop", key_valid, 0);
    check("t4_xfer", last_code, 1);
    check("t4_events", n_ev, 4);
    force_low = 4'b0101;
    ticks(6);
    check("t5_multi", n_ev, 4);
    check("t5_multi_held", key_held, 0);
    c = col_o;
    clks(8);
    check("t5_rotate", col_o, {c[2:0], c[3]});
    force_low = 4'b0000;
    ticks(2);
    key_ready = 1'b0;
    keys_down[2] = 1'b1;
    ticks(8);
    keys_down[2] = 1'b0;
    ticks(6);
    check("t5_pending", key_valid, 1);
    check("t5_pending_code", key_code, 3);
    force_low = 4'b0010;
    clks(12);
    rst_n = 1'b0;
    #1;
    check("t5_rst_col", col_o, 4'b1110);
    check("t5_rst_valid", key_valid, 0);
    check("t5_rst_held", key_held, 0);
    clks(2);
    rst_n = 1'b1;
    key_ready = 1'b1;
    ticks(7);
    check("t5_fresh_code", last_code, 4);
    check("t5_fresh_events", n_ev, 5);
    force_low = 4'b0000;
    ticks(6);
    base = n_ev;
    keys_down[14] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      clks(1);
      ok = key_held;
    end
    check("t6_held", ok, 1);
    clks(96);
    keys_down[14] = 1'b0;
    ticks(6);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("t6_events", n_ev - base, 5);
`else
    check("t6_events", n_ev - base, 1);
`endif
    check("t6_code", last_code, 15);
    check("t6_overrun", n_ovr, 1);
    check("t6_released", key_held, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
